fc_act_writer: RTL and testbench

//  Downstream stage of the fully-connected core. Consumes the FC output-node

---
 rtl/fc_act_writer.sv | 154 +++++++++++++++
 tb/tb_fc_act_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_act_writer.sv
// FC output-node writer: ReLU + arithmetic requantisation shift into the next layer's ifmap buffer.
// Optional build macro FC_ACT_ARGMAX_EN adds class_o/class_vld_o (argmax over accepted beats).
module fc_act_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] node_num_i,
  input  logic [DATA_W-1:0] psum_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic              clr_err_i,
  output logic              wren_o,
  output logic [ADDR_W-1:0] wrptr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              done_o,
  output logic              busy_o,
`ifdef FC_ACT_ARGMAX_EN
  output logic [ADDR_W-1:0] class_o,
  output logic              class_vld_o,
`endif
  output logic              err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   num_q, num_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   wrptr_q, wrptr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                beat0;
  logic [ADDR_W-1:0]   num_eff;
  logic                overrun;
  logic                write;
  logic                early_last;
  logic [DATA_W-1:0]   y;

  always_comb begin
    // Any beat outside RUN (IDLE or DONE) opens a new vector.
    beat0      = (state_q != ST_RUN);
    num_eff    = beat0 ? node_num_i : num_q;
    overrun    = valid_i && (cnt_q == num_eff);
    write      = valid_i && !overrun;
    early_last = write && last_i &&
                 (({1'b0, cnt_q} + 1'b1) < {1'b0, num_eff});
    y          = psum_i[DATA_W-1] ? '0 : (psum_i >> SHIFT);

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_i) state_d = last_i ? ST_DONE : ST_RUN;
      ST_RUN:  if (valid_i && last_i) state_d = ST_DONE;
      ST_DONE: state_d = valid_i ? (last_i ? ST_DONE : ST_RUN) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cnt_d = cnt_q;
    if (valid_i && last_i) cnt_d = '0;
    else if (write)        cnt_d = cnt_q + 1'b1;

    num_d   = (valid_i && beat0) ? node_num_i : num_q;
    wren_d  = write;
    wrptr_d = write ? cnt_q : wrptr_q;
    wdata_d = write ? y : wdata_q;
    done_d  = (state_q == ST_DONE);
    busy_d  = (state_d == ST_RUN);

    // A fresh error outranks a simultaneous clear.
    err_d = err_q;
    if (overrun || early_last) err_d = 1'b1;
    else if (clr_err_i)        err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      wren_q  <= 1'b0;
      wrptr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      wren_q  <= wren_d;
      wrptr_q <= wrptr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign wren_o  = wren_q;
  assign wrptr_o = wrptr_q;
  assign wdata_o = wdata_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

`ifdef FC_ACT_ARGMAX_EN
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [ADDR_W-1:0] best_idx_q, best_idx_d;
  logic              have_q, have_d;
  logic [ADDR_W-1:0] class_q, class_d;
  logic              class_vld_q, class_vld_d;

  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    have_d     = (valid_i && beat0) ? 1'b0 : have_q;
    // Strict compare keeps the lowest index on ties.
    if (write && (beat0 || !have_q || ($signed(psum_i) > $signed(best_val_q)))) begin
      best_val_d = psum_i;
      best_idx_d = cnt_q;
      have_d     = 1'b1;
    end
    class_vld_d = (state_q == ST_DONE);
    class_d     = class_q;
    if (state_q == ST_DONE) class_d = have_q ? best_idx_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_val_q  <= '0;
      best_idx_q  <= '0;
      have_q      <= 1'b0;
      class_q     <= '0;
      class_vld_q <= 1'b0;
    end else begin
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      have_q      <= have_d;
      class_q     <= class_d;
      class_vld_q <= class_vld_d;
    end
  end

  assign class_o     = class_q;
  assign class_vld_o = class_vld_q;
`endif

endmodule

// File: tb/tb_fc_act_writer.sv
// Bench for fc_act_writer: directed table, hand sequences (reset, argmax/shift), random vs. vector-level model.
module tb_fc_act_writer;
  localparam int DW = 8;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] node_num;
  logic [DW-1:0] psum;
  logic valid, last, clr_err;

  logic          wren0, done0, busy0, err0;
  logic [AW-1:0] ptr0;
  logic [DW-1:0] data0;
  logic          wren2, done2, busy2, err2;
  logic [AW-1:0] ptr2;
  logic [DW-1:0] data2;
`ifdef FC_ACT_ARGMAX_EN
  logic [AW-1:0] cls0, cls2;
  logic          cvld0, cvld2;
`endif

  always #5 clk = ~clk;

  fc_act_writer #(.DATA_W(DW), .ADDR_W(AW), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .node_num_i(node_num), .psum_i(psum), .valid_i(valid),
    .last_i(last), .clr_err_i(clr_err), .wren_o(wren0), .wrptr_o(ptr0),
    .wdata_o(data0), .done_o(done0), .busy_o(busy0),
`ifdef FC_ACT_ARGMAX_EN
    .class_o(cls0), .class_vld_o(cvld0),
`endif
    .err_o(err0));

  fc_act_writer #(.DATA_W(DW), .ADDR_W(AW), .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .node_num_i(node_num), .psum_i(psum), .valid_i(valid),
    .last_i(last), .clr_err_i(clr_err), .wren_o(wren2), .wrptr_o(ptr2),
    .wdata_o(data2), .done_o(done2), .busy_o(busy2),
`ifdef FC_ACT_ARGMAX_EN
    .class_o(cls2), .class_vld_o(cvld2),
`endif
    .err_o(err2));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [AW-1:0] n, input logic v, input logic l,
                       input logic [DW-1:0] p, input logic c);
    node_num = n; valid = v; last = l; psum = p; clr_err = c;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] num; logic v, l, c; logic [DW-1:0] ps;
    logic ew; logic [AW-1:0] ep; logic [DW-1:0] ed; logic edn, eb, ee;
  } vec_t;
  vec_t tbl[26];

  function automatic vec_t mk(int num, bit v, bit l, int ps, bit c,
                              bit ew, int ep, int ed, bit edn, bit eb, bit ee);
    vec_t r;
    r.num = AW'(num); r.v = v; r.l = l; r.ps = DW'(ps); r.c = c;
    r.ew = ew; r.ep = AW'(ep); r.ed = DW'(ed); r.edn = edn; r.eb = eb; r.ee = ee;
    return r;
  endfunction

  // Vector-level reference model
  bit            m_active, m_err, m_wren, m_done, m_busy, m_pend, m_cvld;
  int            m_cnt, m_num, m_ptr, m_d0, m_d2, m_class, m_pend_class;
  byte           m_vals[$];

  function automatic int relu_shift(byte v, int sh);
    return (v < 0) ? 0 : (int'(v) >>> sh);
  endfunction

  function automatic int argmax(byte q[$]);
    int bi = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] > q[bi]) bi = i;
    return bi;
  endfunction

  task automatic model_reset();
    m_active = 0; m_err = 0; m_wren = 0; m_done = 0; m_busy = 0; m_pend = 0; m_cvld = 0;
    m_cnt = 0; m_num = 0; m_ptr = 0; m_d0 = 0; m_d2 = 0; m_class = 0; m_pend_class = 0;
    m_vals.delete();
  endtask

  task automatic model_step(int n, bit v, bit l, byte p, bit c);
    bit nerr = 0;
    m_done = m_pend; m_cvld = m_pend;
    if (m_pend) m_class = m_pend_class;
    m_pend = 0; m_wren = 0;
    if (v) begin
      if (!m_active) begin m_num = n; m_cnt = 0; m_vals.delete(); end
      if (m_cnt == m_num) nerr = 1;
      else begin
        m_wren = 1; m_ptr = m_cnt; m_d0 = relu_shift(p, 0); m_d2 = relu_shift(p, 2);
        m_vals.push_back(p); m_cnt++;
        if (l && m_cnt < m_num) nerr = 1;
      end
      if (l) begin
        m_active = 0; m_pend = 1; m_pend_class = (m_vals.size() > 0) ? argmax(m_vals) : 0;
      end else m_active = 1;
    end
    m_err = nerr ? 1'b1 : (c ? 1'b0 : m_err);
    m_busy = m_active;
  endtask

  task automatic check_all_model();
    chk("wren0", wren0, m_wren);   chk("wren2", wren2, m_wren);
    chk("ptr0", ptr0, m_ptr);      chk("ptr2", ptr2, m_ptr);
    chk("data0", data0, m_d0);     chk("data2", data2, m_d2);
    chk("done0", done0, m_done);   chk("done2", done2, m_done);
    chk("busy0", busy0, m_busy);   chk("err0", err0, m_err);
    chk("err2", err2, m_err);
`ifdef FC_ACT_ARGMAX_EN
    chk("cvld0", cvld0, m_cvld);   chk("class0", cls0, m_class);
`endif
  endtask

  initial begin
    // Directed table: inputs for one cycle, outputs expected after that edge.
    tbl[0]  = mk(4, 1, 0,    5, 0, 1, 0,   5, 0, 1, 0);
    tbl[1]  = mk(4, 1, 0,   -3, 0, 1, 1,   0, 0, 1, 0);
    tbl[2]  = mk(4, 1, 0,  127, 0, 1, 2, 127, 0, 1, 0);
    tbl[3]  = mk(4, 1, 1,    0, 0, 1, 3,   0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,    0, 0, 0, 3,   0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0,    0, 0, 0, 3,   0, 0, 0, 0);
    tbl[6]  = mk(2, 1, 0,   10, 0, 1, 0,  10, 0, 1, 0);
    tbl[7]  = mk(2, 1, 1,   20, 0, 1, 1,  20, 0, 0, 0);
    tbl[8]  = mk(2, 1, 0,   30, 0, 1, 0,  30, 1, 1, 0);
    tbl[9]  = mk(2, 1, 1,   40, 0, 1, 1,  40, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,    0, 0, 0, 1,  40, 1, 0, 0);
    tbl[11] = mk(3, 1, 0,    1, 0, 1, 0,   1, 0, 1, 0);
    tbl[12] = mk(3, 1, 0,    2, 0, 1, 1,   2, 0, 1, 0);
    tbl[13] = mk(3, 1, 0,    3, 0, 1, 2,   3, 0, 1, 0);
    tbl[14] = mk(3, 1, 0,    4, 0, 0, 2,   3, 0, 1, 1);
    tbl[15] = mk(3, 1, 1,    5, 0, 0, 2,   3, 0, 0, 1);
    tbl[16] = mk(0, 0, 0,    0, 1, 0, 2,   3, 1, 0, 0);
    tbl[17] = mk(4, 1, 0,    7, 0, 1, 0,   7, 0, 1, 0);
    tbl[18] = mk(4, 1, 1,   -8, 0, 1, 1,   0, 0, 0, 1);
    tbl[19] = mk(0, 0, 0,    0, 0, 0, 1,   0, 1, 0, 1);
    tbl[20] = mk(0, 0, 0,    0, 1, 0, 1,   0, 0, 0, 0);
    tbl[21] = mk(0, 1, 1,    9, 1, 0, 1,   0, 0, 0, 1);
    tbl[22] = mk(0, 0, 0,    0, 0, 0, 1,   0, 1, 0, 1);
    tbl[23] = mk(0, 0, 0,    0, 1, 0, 1,   0, 0, 0, 0);
    tbl[24] = mk(1, 1, 1,   50, 0, 1, 0,  50, 0, 0, 0);
    tbl[25] = mk(0, 0, 0,    0, 0, 0, 0,  50, 1, 0, 0);

    do_reset();
    chk("rst_wren", wren0, 0); chk("rst_ptr", ptr0, 0); chk("rst_data", data0, 0);
    chk("rst_done", done0, 0); chk("rst_busy", busy0, 0); chk("rst_err", err0, 0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].num, tbl[i].v, tbl[i].l, tbl[i].ps, tbl[i].c);
      tick();
      chk($sformatf("t%0d_wren", i), wren0, tbl[i].ew);
      chk($sformatf("t%0d_ptr", i),  ptr0,  tbl[i].ep);
      chk($sformatf("t%0d_data", i), data0, tbl[i].ed);
      chk($sformatf("t%0d_done", i), done0, tbl[i].edn);
      chk($sformatf("t%0d_busy", i), busy0, tbl[i].eb);
      chk($sformatf("t%0d_err", i),  err0,  tbl[i].ee);
    end

    // Asynchronous reset mid-vector abandons it without done_o.
    do_reset();
    drive(10, 1, 0, 11, 0); tick();
    drive(10, 1, 0, 12, 0); tick();
    drive(10, 0, 0, 0, 0);
    #2 rst = 1'b1; #1;
    chk("arst_wren", wren0, 0); chk("arst_ptr", ptr0, 0); chk("arst_data", data0, 0);
    chk("arst_busy", busy0, 0); chk("arst_done", done0, 0); chk("arst_err", err0, 0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); chk("arst_nodone", done0, 0); end
    drive(3, 1, 0, 33, 0); tick();
    chk("arst_next_wren", wren0, 1); chk("arst_next_ptr", ptr0, 0); chk("arst_next_data", data0, 33);

    // Argmax with ties and the SHIFT=2 path.
    do_reset();
    drive(4, 1, 0, 3, 0);  tick();
    drive(4, 1, 0, 9, 0);  tick();
    chk("sh0_9", data0, 9); chk("sh2_9", data2, 2);
    drive(4, 1, 0, -1, 0); tick();
    drive(4, 1, 1, 9, 0);  tick();
    drive(0, 0, 0, 0, 0);  tick();
    chk("am_done", done0, 1); chk("am_err", err0, 0);
`ifdef FC_ACT_ARGMAX_EN
    chk("am_class", cls0, 1); chk("am_cvld", cvld0, 1);
    tick();
    chk("am_hold", cls0, 1); chk("am_cvld_off", cvld0, 0);
`endif

    // Randomised run against the model, with occasional async resets.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int  n;
      bit  v, l, c;
      byte p;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1; #1;
        model_reset();
        check_all_model();
        tick(); rst = 1'b0;
        continue;
      end
      n = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 19) == 0);
      p = byte'($urandom);
      drive(AW'(n), v, l, DW'(p), c);
      tick();
      model_step(n, v, l, p, c);
      check_all_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
